// File: rtl/b2bcd_arbiter.sv
// b2bcd_arbiter: round-robin arbiter sequencing N_REQ requesters through one shared B2BCD converter
module b2bcd_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [8*N_REQ-1:0]         data_in,
    output logic [N_REQ-1:0]           ack,
    output logic [11:0]                bcd_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [7:0]                 conv_bin,
    input  logic [3:0]                 conv_hundreds,
    input  logic [3:0]                 conv_tens,
    input  logic [3:0]                 conv_ones
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic settled;
    function automatic int wrap(input int v);
        return v >= N_REQ ? v - N_REQ : v;
    endfunction
    // scanning from the far end lets the closest-to-ptr requester overwrite the rest
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[wrap(int'(ptr_q) + k)]) win = IW'(wrap(int'(ptr_q) + k));
    end
    assign settled = cnt_q == 4'(SETTLE - 1);
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ack_q   <= ack_d;
        end
    always_comb begin
        state_d = state_q == IDLE ? (|req ? WAIT : IDLE)
                : state_q == WAIT ? (settled ? ACK : WAIT)
                : IDLE;
    end
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ack_d   = '0;
        if (state_q == IDLE && |req) begin
            grant_d = win;
            bin_d   = data_in[8*int'(win) +: 8];
            cnt_d   = '0;
        end
        if (state_q == WAIT) begin
            cnt_d = cnt_q + 4'd1;
            if (settled) begin
                bcd_d          = {conv_hundreds, conv_tens, conv_ones};
                ack_d[grant_q] = 1'b1;
            end
        end
        if (state_q == ACK)
            ptr_d = int'(grant_q) == N_REQ - 1 ? '0 : grant_q + IW'(1);
    end
    assign ack      = ack_q;
    assign bcd_out  = bcd_q;
    assign grant_id = grant_q;
    assign conv_bin = bin_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_b2bcd_arbiter.sv
// tb_b2bcd_arbiter: directed checks of two arbiter instances (SETTLE=1 and SETTLE=3) with a behavioural B2BCD
module tb_b2bcd_arbiter;
    logic clk = 1'b0, rst = 1'b1, mon = 1'b0;
    logic [3:0] req_a = '0, req_b = '0, ack_a, ack_b;
    logic [31:0] data_a = '0, data_b = '0;
    logic [11:0] bcd_a, bcd_b, cv_a, cv_b;
    logic [1:0] gid_a, gid_b;
    logic busy_a, busy_b;
    logic [7:0] bin_a, bin_b;
    int total = 0, bad = 0;
    int exp_ch [4];
    logic [11:0] exp_bcd [4];
    always #5 clk = ~clk;
    function automatic logic [11:0] bcd_fn(input logic [7:0] v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    assign cv_a = bcd_fn(bin_a);
    assign cv_b = bcd_fn(bin_b);
    b2bcd_arbiter #(.N_REQ(4), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .data_in(data_a), .ack(ack_a), .bcd_out(bcd_a),
        .grant_id(gid_a), .busy(busy_a), .conv_bin(bin_a),
        .conv_hundreds(cv_a[11:8]), .conv_tens(cv_a[7:4]), .conv_ones(cv_a[3:0]));
    b2bcd_arbiter #(.N_REQ(4), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .data_in(data_b), .ack(ack_b), .bcd_out(bcd_b),
        .grant_id(gid_b), .busy(busy_b), .conv_bin(bin_b),
        .conv_hundreds(cv_b[11:8]), .conv_tens(cv_b[7:4]), .conv_ones(cv_b[3:0]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk)
        if (mon) begin
            chk("onehot_a", 32'($onehot0(ack_a)), 32'd1);
            chk("onehot_b", 32'($onehot0(ack_b)), 32'd1);
        end
    task automatic do_reset();
        rst = 1'b1;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic xact(input bit sel, input int ch, input logic [7:0] v,
                        output int lat, output logic [11:0] got, output logic [3:0] gack);
        lat = 0;
        gack = '0;
        got = '0;
        if (sel) begin data_b[8*ch +: 8] = v; req_b[ch] = 1'b1; end
        else begin data_a[8*ch +: 8] = v; req_a[ch] = 1'b1; end
        while (gack == 0 && lat < 30) begin
            @(negedge clk);
            lat++;
            gack = sel ? ack_b : ack_a;
            got  = sel ? bcd_b : bcd_a;
        end
        if (gack == 0) chk("ack_timeout", 32'(lat), 32'd0);
        if (sel) req_b[ch] = 1'b0; else req_a[ch] = 1'b0;
        @(negedge clk);
    endtask
    task automatic run_seq(input logic [3:0] r, input int n, input bit drop);
        int got = 0, cyc = 0, last = 0;
        req_a = r;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack_a != 0) begin
                chk("seq_ack", 32'(ack_a), 32'(1) << exp_ch[got]);
                chk("seq_bcd", 32'(bcd_a), 32'(exp_bcd[got]));
                if (got > 0) chk("seq_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                if (drop) req_a[exp_ch[got]] = 1'b0;
                got++;
            end
        end
        chk("seq_cnt", 32'(got), 32'(n));
        req_a = '0;
        @(negedge clk);
    endtask
    initial begin
        int lat;
        logic [11:0] got;
        logic [3:0] gack;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack_a), 32'd0);
        chk("rst_bcd", 32'(bcd_a), 32'd0);
        chk("rst_gid", 32'(gid_a), 32'd0);
        chk("rst_bin", 32'(bin_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        mon = 1'b1;
        // single request, SETTLE=1
        data_a[7:0] = 8'd255;
        req_a = 4'b0001;
        @(negedge clk);
        chk("t1_busy_g", 32'(busy_a), 32'd1);
        chk("t1_gid", 32'(gid_a), 32'd0);
        chk("t1_bin", 32'(bin_a), 32'd255);
        chk("t1_ack_early", 32'(ack_a), 32'd0);
        @(negedge clk);
        chk("t1_ack", 32'(ack_a), 32'b0001);
        chk("t1_bcd", 32'(bcd_a), 32'h255);
        chk("t1_busy_a", 32'(busy_a), 32'd1);
        req_a = '0;
        @(negedge clk);
        chk("t1_ack_fall", 32'(ack_a), 32'd0);
        chk("t1_busy_fall", 32'(busy_a), 32'd0);
        chk("t1_bcd_hold", 32'(bcd_a), 32'h255);
        @(negedge clk);
        chk("t1_idle", 32'(busy_a), 32'd0);
        // simultaneous requests
        do_reset();
        data_a = {8'd200, 8'd100, 8'd99, 8'd0};
        exp_ch = '{0, 1, 2, 3};
        exp_bcd = '{12'h000, 12'h099, 12'h100, 12'h200};
        run_seq(4'b1111, 4, 1'b1);
        // fairness: ch1 and ch3 held continuously
        do_reset();
        data_a = {8'd8, 8'd0, 8'd7, 8'd0};
        exp_ch = '{1, 3, 1, 3};
        exp_bcd = '{12'h007, 12'h008, 12'h007, 12'h008};
        run_seq(4'b1010, 4, 1'b0);
        // data changed after grant
        do_reset();
        data_a[23:16] = 8'd42;
        req_a = 4'b0100;
        @(negedge clk);
        data_a[23:16] = 8'd77;
        chk("t4_bin", 32'(bin_a), 32'd42);
        @(negedge clk);
        chk("t4_ack", 32'(ack_a), 32'b0100);
        chk("t4_bcd", 32'(bcd_a), 32'h042);
        req_a = '0;
        @(negedge clk);
        // reset mid-operation, SETTLE=3; a finished ch2 leaves ptr at 3
        do_reset();
        xact(1'b1, 2, 8'd123, lat, got, gack);
        chk("t5_lat", 32'(lat), 32'd4);
        chk("t5_pre_ack", 32'(gack), 32'b0100);
        chk("t5_pre_bcd", 32'(got), 32'h123);
        data_b[15:8] = 8'd45;
        req_b = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("t5_wait", 32'(busy_b), 32'd1);
        rst = 1'b1;
        req_b = '0;
        @(negedge clk);
        chk("t5_rst_ack", 32'(ack_b), 32'd0);
        chk("t5_rst_bcd", 32'(bcd_b), 32'd0);
        chk("t5_rst_gid", 32'(gid_b), 32'd0);
        chk("t5_rst_bin", 32'(bin_b), 32'd0);
        chk("t5_rst_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_no_ack", 32'(ack_b), 32'd0);
        data_b[31:24] = 8'd33;
        req_b = 4'b1001;
        xact(1'b1, 0, 8'd11, lat, got, gack);
        chk("t5_first_ack", 32'(gack), 32'b0001);
        chk("t5_first_bcd", 32'(got), 32'h011);
        xact(1'b1, 3, 8'd33, lat, got, gack);
        chk("t5_second_ack", 32'(gack), 32'b1000);
        chk("t5_second_bcd", 32'(got), 32'h033);
        // exhaustive sweep on both instances
        do_reset();
        for (int v = 0; v < 256; v++) begin
            xact(1'b0, 0, 8'(v), lat, got, gack);
            chk("sweep_a_ack", 32'(gack), 32'b0001);
            chk("sweep_a_bcd", 32'(got), 32'(bcd_fn(8'(v))));
            if (v == 0) chk("sweep_a_lat", 32'(lat), 32'd2);
        end
        for (int v = 0; v < 256; v++) begin
            xact(1'b1, 0, 8'(v), lat, got, gack);
            chk("sweep_b_ack", 32'(gack), 32'b0001);
            chk("sweep_b_bcd", 32'(got), 32'(bcd_fn(8'(v))));
            if (v == 0) chk("sweep_b_lat", 32'(lat), 32'd4);
        end
        mon = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
